cla_addsub_pipe: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes and signed/unsigned modes. It generalises the team's fixed 8-bit combinational CLA to any width, group size and pipeline depth. It returns a full-precision WIDTH+1-bit result plus carry and overflow flags. It sits in the ALU datapath between operand issue and writeback, and accepts one operation per cycle when not stalled.

---
 rtl/cla_addsub_pipe.sv | 152 +++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with a WIDTH+1-bit exact result.
// Lookahead groups are split across the register stages, and each stage has a valid/ready handshake.
module cla_addsub_pipe #(
  parameter int WIDTH  = 8,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGROUPS = (WIDTH + BLOCK - 1) / BLOCK;
  localparam int BASE    = NGROUPS / STAGES;
  localparam int EXTRA   = NGROUPS % STAGES;

  // Earlier stages absorb the remainder groups.
  function automatic int first_group(input int k);
    return k * BASE + ((k < EXTRA) ? k : EXTRA);
  endfunction

  // Two-level lookahead carry into bit 'hi' from the carry entering bit 'lo'.
  function automatic logic lookahead(input logic [WIDTH:0] x, input logic [WIDTH:0] y,
                                     input logic c0, input int lo, input int hi);
    logic gg, pp;
    gg = 1'b0;
    pp = 1'b1;
    for (int m = hi - 1; m >= lo; m--) begin
      gg = gg | (pp & x[m] & y[m]);
      pp = pp & (x[m] ^ y[m]);
    end
    return gg | (pp & c0);
  endfunction

  logic [STAGES-1:0] valid_vec;
  logic [STAGES-1:0] en;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : stage
      localparam int G_LO = first_group(gi);
      localparam int G_HI = first_group(gi + 1);

      logic [WIDTH:0]   x_in, y_in;
      logic [WIDTH-1:0] s_in, s_next;
      logic             c_in, c_next, sgn_in, v_in;
      logic             v_reg;

      if (gi == 0) begin : src
        // Subtraction is a + ~b + !cin over the extended operands.
        assign x_in   = {sgn & a[WIDTH-1], a};
        assign y_in   = {sgn & b[WIDTH-1], b} ^ {(WIDTH + 1){sub}};
        assign s_in   = '0;
        assign c_in   = cin ^ sub;
        assign sgn_in = sgn;
        assign v_in   = in_valid;
      end else begin : src
        assign x_in   = stage[gi-1].mid.x_reg;
        assign y_in   = stage[gi-1].mid.y_reg;
        assign s_in   = stage[gi-1].mid.s_reg;
        assign c_in   = stage[gi-1].mid.c_reg;
        assign sgn_in = stage[gi-1].mid.sgn_reg;
        assign v_in   = stage[gi-1].v_reg;
      end

      // A stage is blocked only if it and every stage after it are full and the sink stalls.
      assign en[gi]        = ~((&valid_vec[STAGES-1:gi]) & ~out_ready);
      assign valid_vec[gi] = v_reg;

      always_comb begin
        s_next = s_in;
        c_next = c_in;
        for (int g = G_LO; g < G_HI; g++) begin
          for (int i = g * BLOCK; (i < g * BLOCK + BLOCK) && (i < WIDTH); i++) begin
            s_next[i] = x_in[i] ^ y_in[i] ^ lookahead(x_in, y_in, c_next, g * BLOCK, i);
          end
          c_next = lookahead(x_in, y_in, c_next, g * BLOCK,
                             (g * BLOCK + BLOCK < WIDTH) ? g * BLOCK + BLOCK : WIDTH);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_reg <= 1'b0;
        end else if (en[gi]) begin
          v_reg <= v_in;
        end
      end

      if (gi < STAGES - 1) begin : mid
        logic [WIDTH:0]   x_reg, y_reg;
        logic [WIDTH-1:0] s_reg;
        logic             c_reg, sgn_reg;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            x_reg   <= '0;
            y_reg   <= '0;
            s_reg   <= '0;
            c_reg   <= 1'b0;
            sgn_reg <= 1'b0;
          end else if (en[gi] && v_in) begin
            x_reg   <= x_in;
            y_reg   <= y_in;
            s_reg   <= s_next;
            c_reg   <= c_next;
            sgn_reg <= sgn_in;
          end
        end
      end else begin : last
        logic [WIDTH:0] full_next;
        logic           ovf_next;
        logic [WIDTH:0] sum_reg;
        logic           cout_reg, ovf_reg;

        assign full_next = {x_in[WIDTH] ^ y_in[WIDTH] ^ c_next, s_next};
        assign ovf_next  = sgn_in ? (full_next[WIDTH] ^ full_next[WIDTH-1]) : full_next[WIDTH];

        // Loading only on a real beat keeps the outputs stable while stalled.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
          end else if (en[gi] && v_in) begin
            sum_reg  <= full_next;
            cout_reg <= c_next;
            ovf_reg  <= ovf_next;
          end
        end

        assign sum       = sum_reg;
        assign cout      = cout_reg;
        assign ovf       = ovf_reg;
        assign out_valid = v_reg;
      end
    end
  endgenerate

  assign in_ready = en[0];

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe: four parameter sets against an exact-arithmetic model.
// It uses a scoreboard to check ordering, latency, backpressure and reset behaviour.
module tb_cla_addsub_pipe;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] in_valid, out_ready, cin, sub, sgn;
  logic [31:0]  a [N];
  logic [31:0]  b [N];
  wire  [N-1:0] in_ready, out_valid, cout, ovf;
  wire  [8:0]   sum0;
  wire  [13:0]  sum1;
  wire  [2:0]   sum2;
  wire  [32:0]  sum3;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          t;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  cla_addsub_pipe #(.WIDTH(8),  .BLOCK(4), .STAGES(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0][7:0]), .b(b[0][7:0]), .cin(cin[0]), .sub(sub[0]), .sgn(sgn[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum0), .cout(cout[0]), .ovf(ovf[0]));
  cla_addsub_pipe #(.WIDTH(13), .BLOCK(5), .STAGES(3)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1][12:0]), .b(b[1][12:0]), .cin(cin[1]), .sub(sub[1]), .sgn(sgn[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum1), .cout(cout[1]), .ovf(ovf[1]));
  cla_addsub_pipe #(.WIDTH(2),  .BLOCK(1), .STAGES(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2][1:0]), .b(b[2][1:0]), .cin(cin[2]), .sub(sub[2]), .sgn(sgn[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum2), .cout(cout[2]), .ovf(ovf[2]));
  cla_addsub_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(8)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .a(a[3]), .b(b[3]), .cin(cin[3]), .sub(sub[3]), .sgn(sgn[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .sum(sum3), .cout(cout[3]), .ovf(ovf[3]));

  function automatic int wof(int k);
    case (k)
      0: return 8;
      1: return 13;
      2: return 2;
      default: return 32;
    endcase
  endfunction

  function automatic int sof(int k);
    case (k)
      0: return 2;
      1: return 3;
      2: return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] get_sum(int k);
    case (k)
      0: return 64'(sum0);
      1: return 64'(sum1);
      2: return 64'(sum2);
      default: return 64'(sum3);
    endcase
  endfunction

  // Exact integer arithmetic over the operands as numbers, then the flag definitions.
  function automatic exp_t model(int k, logic [31:0] av, logic [31:0] bv, bit c, bit s, bit g, int t);
    exp_t   e;
    int     w;
    longint m, ua, ub, ea, eb, r, wr, raw;
    w   = wof(k);
    m   = longint'(1) << w;
    ua  = longint'(64'(av)) & (m - 1);
    ub  = longint'(64'(bv)) & (m - 1);
    ea  = (g && ua >= m / 2) ? ua - m : ua;
    eb  = (g && ub >= m / 2) ? ub - m : ub;
    r   = s ? (ea - eb - longint'(c)) : (ea + eb + longint'(c));
    e.sum  = 64'(r) & 64'((m << 1) - 1);
    raw    = ua + (s ? (m - 1 - ub) : ub) + longint'(s ? !c : c);
    e.cout = ((raw >> w) & 1) != 0;
    wr  = r & (m - 1);
    if (g && wr >= m / 2) wr = wr - m;
    e.ovf = (wr != r);
    e.t   = t;
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One cycle on instance k: drive at the falling edge, observe 1 ns later.
  task automatic step(int k, bit v, logic [31:0] av, logic [31:0] bv, bit c, bit s, bit g, bit ordy);
    bit   ev;
    exp_t e;
    @(negedge clk);
    cyc++;
    in_valid     = '0;
    out_ready    = '1;
    in_valid[k]  = v;
    out_ready[k] = ordy;
    a[k] = av; b[k] = bv; cin[k] = c; sub[k] = s; sgn[k] = g;
    #1;
    chk($sformatf("in_ready[%0d]", k), 64'(in_ready[k]), 64'(!(q.size() == sof(k) && !ordy)));
    ev = (q.size() > 0) && (cyc - q[0].t >= sof(k));
    chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(ev));
    if (ev) begin
      chk($sformatf("sum[%0d]", k),  get_sum(k),        q[0].sum);
      chk($sformatf("cout[%0d]", k), 64'(cout[k]),      64'(q[0].cout));
      chk($sformatf("ovf[%0d]", k),  64'(ovf[k]),       64'(q[0].ovf));
      if (ordy) void'(q.pop_front());
    end
    if (v && in_ready[k]) begin
      e = model(k, av, bv, c, s, g, cyc);
      q.push_back(e);
    end
  endtask

  task automatic drain(int k);
    for (int i = 0; i < 40 && q.size() > 0; i++) step(k, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(k, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Single beat held at the output, checked against hand-derived constants.
  task automatic one_shot(string tag, int k, logic [31:0] av, logic [31:0] bv, bit c, bit s, bit g,
                          logic [63:0] es, bit ec, bit eo);
    step(k, 1'b1, av, bv, c, s, g, 1'b0);
    for (int i = 0; i < sof(k) + 2 && !out_valid[k]; i++)
      step(k, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".valid"}, 64'(out_valid[k]), 64'd1);
    chk({tag, ".sum"},   get_sum(k),        es);
    chk({tag, ".cout"},  64'(cout[k]),      64'(ec));
    chk({tag, ".ovf"},   64'(ovf[k]),       64'(eo));
    drain(k);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = '0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst.out_valid[%0d]", k), 64'(out_valid[k]), 64'd0);
      chk($sformatf("rst.sum[%0d]", k),       get_sum(k),        64'd0);
      chk($sformatf("rst.cout[%0d]", k),      64'(cout[k]),      64'd0);
      chk($sformatf("rst.ovf[%0d]", k),       64'(ovf[k]),       64'd0);
      chk($sformatf("rst.in_ready[%0d]", k),  64'(in_ready[k]),  64'd1);
    end
    q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int jl[16] = '{-128, -127, -64, -2, -1, 0, 1, 2, 3, 63, 64, 100, 125, 126, 127, -100};
    int sent;
    rst = 1'b1;
    in_valid = '0; out_ready = '1; cin = '0; sub = '0; sgn = '0;
    for (int k = 0; k < N; k++) begin a[k] = '0; b[k] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    apply_reset();

    // Hand-derived boundary cases on the 8-bit, 2-stage instance.
    one_shot("s_m128_m128", 0, 32'h80, 32'h80, 1'b0, 1'b0, 1'b1, 64'h100, 1'b1, 1'b1);
    one_shot("s_127_p1",    0, 32'h7F, 32'h01, 1'b0, 1'b0, 1'b1, 64'h080, 1'b0, 1'b1);
    one_shot("u_255_255_c", 0, 32'hFF, 32'hFF, 1'b1, 1'b0, 1'b0, 64'h1FF, 1'b1, 1'b1);
    one_shot("u_3_sub_5",   0, 32'h03, 32'h05, 1'b0, 1'b1, 1'b0, 64'h1FE, 1'b0, 1'b1);
    one_shot("u_5_sub_3_b", 0, 32'h05, 32'h03, 1'b1, 1'b1, 1'b0, 64'h001, 1'b1, 1'b0);

    // Back-to-back signed additions over all i against a boundary-heavy j set.
    for (int i = -128; i < 128; i++)
      for (int j = 0; j < 16; j++)
        step(0, 1'b1, 32'(i), 32'(jl[j]), 1'b0, 1'b0, 1'b1, 1'b1);
    drain(0);

    // Reset with two beats in flight; they must never reappear.
    step(0, 1'b1, 32'd11, 32'd22, 1'b0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b1, 32'd33, 32'd44, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    cyc++;
    apply_reset();
    one_shot("post_rst_7_8", 0, 32'd7, 32'd8, 1'b0, 1'b0, 1'b0, 64'd15, 1'b0, 1'b0);

    // Backpressure on the 3-stage instance: ten beats, random sink stalls.
    sent = 0;
    for (int i = 0; i < 300 && (sent < 10 || q.size() > 0); i++) begin
      step(1, sent < 10, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 2) == 0);
      if (sent < 10 && in_ready[1]) sent++;
    end
    chk("bp.sent", 64'(sent), 64'd10);
    drain(1);

    // Random streams on every parameter set.
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 300; i++)
        step(k, $urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 3) != 0);
      drain(k);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
